// File: rtl/peripheral_dbg_pu_riscv_cpu_responder_if.sv
// rtl/peripheral_dbg_pu_riscv_cpu_responder_if.sv - strobe/ack debug access bus between debug unit and responder
interface peripheral_dbg_pu_riscv_cpu_responder_if #(
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32
);
    logic                      cpu_stb_i;
    logic                      cpu_we_i;
    logic [CPU_ADDR_WIDTH-1:0] cpu_addr_i;
    logic [CPU_DATA_WIDTH-1:0] cpu_data_i;
    logic [CPU_DATA_WIDTH-1:0] cpu_data_o;
    logic                      cpu_ack_o;

    modport master (
        output cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        input  cpu_data_o, cpu_ack_o
    );

    modport slave (
        input  cpu_stb_i, cpu_we_i, cpu_addr_i, cpu_data_i,
        output cpu_data_o, cpu_ack_o
    );
endinterface

// File: rtl/peripheral_dbg_pu_riscv_cpu_responder.sv
// rtl/peripheral_dbg_pu_riscv_cpu_responder.sv - per-core debug responder: local debug regs, hit/halt logic, core register-port bridge
module peripheral_dbg_pu_riscv_cpu_responder #(
    parameter int CPU_ADDR_WIDTH = 32,
    parameter int CPU_DATA_WIDTH = 32,
    parameter int TIMEOUT        = 255,
    parameter int HART_ID        = 0
) (
    input  logic                      cpu_clk_i,
    input  logic                      cpu_rst_i,
    peripheral_dbg_pu_riscv_cpu_responder_if.slave cpu,
    input  logic                      cpu_stall_i,
    output logic                      cpu_bp_o,
    input  logic [CPU_ADDR_WIDTH-1:0] core_pc_i,
    input  logic                      core_retire_i,
    input  logic                      core_halted_i,
    output logic                      core_halt_o,
    output logic                      core_reg_req_o,
    output logic                      core_reg_we_o,
    output logic                      core_reg_sel_o,
    output logic [11:0]               core_reg_addr_o,
    output logic [CPU_DATA_WIDTH-1:0] core_reg_wdata_o,
    input  logic [CPU_DATA_WIDTH-1:0] core_reg_rdata_i,
    input  logic                      core_reg_ack_i
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, CORE, ACK, DONE} state_t;

    state_t                    state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic [1:0]                ctrl_q;
    logic [1:0]                hit_q, hit_nxt;
    logic [CPU_ADDR_WIDTH-1:0] bpaddr_q;
    logic [CPU_ADDR_WIDTH-1:0] pc_q;
    logic                      halt_q;
    logic [CPU_DATA_WIDTH-1:0] rdata_q;
    logic                      wr_pend_q;
    logic [15:0]               wr_addr_q;
    logic [CPU_DATA_WIDTH-1:0] wr_data_q;

    logic [15:0]               a16;
    logic                      is_gpr, is_csr, is_core;
    logic [11:0]               reg_addr;
    logic [CPU_DATA_WIDTH-1:0] rd_local;
    logic                      cnt_last;
    logic                      local_wr;
    logic                      hit_clr;
    logic                      unused_addr_hi;

    assign a16            = cpu.cpu_addr_i[15:0];
    assign unused_addr_hi = ^cpu.cpu_addr_i[CPU_ADDR_WIDTH-1:16];
    assign is_gpr         = (a16[15:7] == 9'h020);
    assign is_csr         = (a16 >= 16'h2000) && (a16 <= 16'h5FFF);
    assign is_core        = is_gpr | is_csr;
    // CSR window 0x2000..0x5FFC wraps addr[13:2] so that 0x2000 maps to CSR 0x000
    assign reg_addr       = is_gpr ? {7'd0, a16[6:2]} : (a16[13:2] - 12'h800);
    assign cnt_last       = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        rd_local = '0;
        case (a16)
            16'h0000: rd_local = CPU_DATA_WIDTH'(ctrl_q);
            16'h0004: rd_local = CPU_DATA_WIDTH'(hit_q);
            16'h0008: rd_local = CPU_DATA_WIDTH'(bpaddr_q);
            16'h000C: rd_local = CPU_DATA_WIDTH'(pc_q);
            16'h0010: rd_local = CPU_DATA_WIDTH'(HART_ID);
            default:  rd_local = '0;
        endcase
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cpu.cpu_stb_i) state_d = (is_core && core_halted_i) ? CORE : ACK;
            CORE: if (core_reg_ack_i || cnt_last) state_d = ACK;
            ACK:  state_d = DONE;
            DONE: if (!cpu.cpu_stb_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Local writes commit on the edge that closes the ack cycle
    assign local_wr = (state_q == ACK) && wr_pend_q;
    assign hit_clr  = local_wr && (wr_addr_q == 16'h0004) && wr_data_q[0];

    always_comb begin
        hit_nxt = hit_q;
        if (hit_clr) hit_nxt = 2'b00;
        if (core_retire_i && !hit_q[0]) begin
            if (ctrl_q[1] && (core_pc_i == bpaddr_q)) hit_nxt = 2'b01;
            else if (ctrl_q[0])                       hit_nxt = 2'b11;
        end
    end

    always_ff @(posedge cpu_clk_i) begin
        if (cpu_rst_i) begin
            cnt_q            <= '0;
            ctrl_q           <= '0;
            hit_q            <= '0;
            bpaddr_q         <= '0;
            pc_q             <= '0;
            halt_q           <= 1'b0;
            rdata_q          <= '0;
            wr_pend_q        <= 1'b0;
            wr_addr_q        <= '0;
            wr_data_q        <= '0;
            core_reg_we_o    <= 1'b0;
            core_reg_sel_o   <= 1'b0;
            core_reg_addr_o  <= '0;
            core_reg_wdata_o <= '0;
        end else begin
            hit_q  <= hit_nxt;
            halt_q <= cpu_stall_i | hit_nxt[0];
            if (core_retire_i) pc_q <= core_pc_i;

            if (local_wr) begin
                if (wr_addr_q == 16'h0000) ctrl_q   <= wr_data_q[1:0];
                if (wr_addr_q == 16'h0008) bpaddr_q <= CPU_ADDR_WIDTH'(wr_data_q);
            end

            case (state_q)
                IDLE: if (cpu.cpu_stb_i) begin
                    wr_pend_q <= cpu.cpu_we_i && !is_core;
                    wr_addr_q <= a16;
                    wr_data_q <= cpu.cpu_data_i;
                    rdata_q   <= (cpu.cpu_we_i || is_core) ? '0 : rd_local;
                    if (is_core && core_halted_i) begin
                        cnt_q            <= '0;
                        core_reg_we_o    <= cpu.cpu_we_i;
                        core_reg_sel_o   <= is_csr;
                        core_reg_addr_o  <= reg_addr;
                        core_reg_wdata_o <= cpu.cpu_data_i;
                    end
                end
                CORE: begin
                    if (core_reg_ack_i) rdata_q <= core_reg_rdata_i;
                    else if (cnt_last)  rdata_q <= CPU_DATA_WIDTH'(32'hDEADBEEF);
                    else                cnt_q   <= cnt_q + 1'b1;
                end
                ACK:     wr_pend_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign core_reg_req_o = (state_q == CORE);
    assign cpu.cpu_ack_o  = (state_q == ACK);
    assign cpu.cpu_data_o = (state_q == ACK) ? rdata_q : '0;
    assign cpu_bp_o       = hit_q[0];
    assign core_halt_o    = halt_q;

endmodule

// File: doc/peripheral_dbg_pu_riscv_cpu_responder.md
# peripheral_dbg_pu_riscv_cpu_responder

Per-core debug responder on the RISC-V processing-unit side of the CPU/thread debug port. It terminates the strobe/acknowledge access issued by the debug unit's CPU module and serves local debug registers: control, breakpoint, hit status and hart ID. It forwards GPR/CSR accesses to the halted core's register port and drives breakpoint and halt signalling back to the debug unit and the core. One instance per core.

## Interface
Parameters:
- CPU_ADDR_WIDTH, 32, debug address width
- CPU_DATA_WIDTH, 32, debug/core data width
- TIMEOUT, 255, max cycles to wait for core_reg_ack_i (≥1)
- HART_ID, 0, value returned at HARTID register

Ports (one clock; reset is synchronous and active-high):
- cpu_clk_i  in  1  clock, all logic rising-edge
- cpu_rst_i  in  1  synchronous active-high reset
- cpu_stb_i  in  1  access strobe from debug unit, held until ack
- cpu_we_i  in  1  1=write, 0=read; valid with stb
- cpu_addr_i  in  CPU_ADDR_WIDTH  register address; valid with stb
- cpu_data_i  in  CPU_DATA_WIDTH  write data; valid with stb
- cpu_data_o  out  CPU_DATA_WIDTH  read data; valid while cpu_ack_o=1
- cpu_ack_o  out  1  single-cycle access completion
- cpu_stall_i  in  1  stall request from debug unit
- cpu_bp_o  out  1  breakpoint/step hit, equals HIT[0]
- core_pc_i  in  CPU_ADDR_WIDTH  PC of retiring instruction
- core_retire_i  in  1  instruction retires this cycle
- core_halted_i  in  1  core pipeline is halted
- core_halt_o  out  1  halt request to core
- core_reg_req_o  out  1  register-port request, held until ack/timeout
- core_reg_we_o  out  1  register-port write
- core_reg_sel_o  out  1  0=GPR, 1=CSR
- core_reg_addr_o  out  12  GPR index (4:0) or CSR number
- core_reg_wdata_o  out  CPU_DATA_WIDTH  register write data
- core_reg_rdata_i  in  CPU_DATA_WIDTH  register read data, valid with ack
- core_reg_ack_i  in  1  register-port completion

## Operation
Address map, decoded on cpu_addr_i[15:0]; the upper bits are ignored:
- 0x0000 CTRL, RW: bit0 STEP_EN, bit1 BP_EN; other bits read 0.
- 0x0004 HIT, R/W1C: bit0 HIT, bit1 CAUSE (0=breakpoint, 1=step).
- 0x0008 BPADDR, RW, full width.
- 0x000C PC, RO: last retired core_pc_i.
- 0x0010 HARTID, RO: HART_ID.
- 0x1000–0x107C GPR: index = addr[6:2]; x0 writes are forwarded and the core ignores them.
- 0x2000–0x5FFC CSR: number = addr[13:2] - 0x800.
- Any other address: reads return 0, writes are dropped, ack is normal.

Hit logic, evaluated on a core_retire_i cycle while HIT[0]=0:
- BP_EN and core_pc_i==BPADDR: set HIT=1, CAUSE=0.
- Otherwise STEP_EN: set HIT=1, CAUSE=1.
- Breakpoint has priority when both match.
- Writing HIT with bit0=1 clears bits 1:0. A same-cycle set and clear resolves to set.

Halt:
- core_halt_o = cpu_stall_i | HIT[0], registered.
- cpu_bp_o = HIT[0].

FSM states IDLE, CORE, ACK, DONE:
- IDLE: when cpu_stb_i=1:
  - Local or unmapped address: perform the access and go to ACK.
  - GPR/CSR address with core_halted_i=1: go to CORE and raise core_reg_req_o with addr/we/wdata/sel.
  - GPR/CSR address with core_halted_i=0: go to ACK; a read returns 0, a write is dropped.
- CORE: hold the request.
  - On core_reg_ack_i: latch rdata, drop req, go to ACK.
  - When the counter reaches TIMEOUT: drop req, data=0xDEADBEEF, go to ACK.
- ACK: cpu_ack_o=1 for exactly one cycle, then go to DONE.
- DONE: wait for cpu_stb_i=0, then go to IDLE. A strobe held high never retriggers.

Reset:
- All outputs 0; CTRL, HIT, BPADDR, PC cleared; FSM to IDLE; timeout counter 0.
- Reset during CORE drops core_reg_req_o the next cycle, with no ack.

## Timing
- Local access: stb sampled at edge N, ack high in cycle N+1, with cpu_data_o valid in the same cycle. Writes take effect at edge N+1.
- Core access: req high from cycle N+1. core_reg_ack_i sampled at edge M gives cpu_ack_o in cycle M+1. Minimum latency is 2 cycles from stb.
- Timeout: req is held for exactly TIMEOUT cycles, then ack follows in the next cycle.
- Hit: retire at edge N gives cpu_bp_o and core_halt_o high in cycle N+1.
- cpu_data_o is 0 whenever cpu_ack_o=0.
- core_reg_* outputs are stable while req=1.

## Test plan
- Reset with stb=1 held → outputs all 0; after reset release, ack one cycle later; no second ack until stb drops.
- Write BPADDR=0x8000_0010, CTRL=0x2; retire PCs 0x8000_000C then 0x8000_0010 → cpu_bp_o and core_halt_o high the cycle after the second retire; HIT reads 0x1; write HIT=0x1 → bp_o=0 next cycle.
- CTRL=0x1, retire any PC → HIT reads 0x3; with CTRL=0x3 and PC==BPADDR → HIT reads 0x1.
- core_halted_i=1, read addr 0x1014 → req with sel=0, addr=5; core ack returning 0x1234_5678 on cycle 3 → cpu_data_o=0x1234_5678 with ack one cycle later.
- Write 0x2C00 (CSR 0x300) with core_reg_ack_i never asserted, TIMEOUT=4 → req high exactly 4 cycles, then ack; a read of the same address returns 0xDEADBEEF.
- core_halted_i=0, read 0x1000 → ack in 1 cycle, data 0, req never asserted; unmapped 0x0F00 reads 0.
